// File: rtl/video_render_seq.sv
// Per-line render scheduler: sequences layer 0, layer 1 and sprite renderers
// one at a time per display line, flips the line buffer and raises interrupts.
//
// Ports:
//   clk, rst                 pixel clock, async active-high reset
//   start_of_screen          strobe on the last pixel before display line 0
//   start_of_line            strobe on the last pixel of every line
//   end_of_screen            strobe on the last pixel of the last active line
//   l0_en/l1_en/spr_en       stage enables, sampled at each kick
//   l0_done/l1_done/spr_done renderer completion pulses
//   irq_line_cfg             line-compare value
//   overrun_clr              clears the sticky overrun flag
//   l0_start/l1_start/spr_start  one-cycle start pulses
//   render_line              line the renderers must produce
//   linebuf_sel              line-buffer half being written
//   render_abort             one-cycle abort of the active renderer
//   busy                     high while any stage is pending
//   overrun                  sticky, set when a render is aborted
//   line_irq                 one-cycle pulse on line compare
//   vsync_irq                one-cycle pulse after end_of_screen
module video_render_seq #(
  parameter int NUM_LINES = 480,
  parameter int LINE_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_of_screen,
  input  logic              start_of_line,
  input  logic              end_of_screen,
  input  logic              l0_en,
  input  logic              l1_en,
  input  logic              spr_en,
  input  logic              l0_done,
  input  logic              l1_done,
  input  logic              spr_done,
  input  logic [LINE_W-1:0] irq_line_cfg,
  input  logic              overrun_clr,
  output logic              l0_start,
  output logic              l1_start,
  output logic              spr_start,
  output logic [LINE_W-1:0] render_line,
  output logic              linebuf_sel,
  output logic              render_abort,
  output logic              busy,
  output logic              overrun,
  output logic              line_irq,
  output logic              vsync_irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L0   = 2'd1,
    L1   = 2'd2,
    SPR  = 2'd3
  } state_t;

  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(NUM_LINES - 1);

  state_t            state_q;
  logic [2:0]        en_q;
  logic              frame_active_q;
  logic [LINE_W-1:0] render_line_q;
  logic              linebuf_sel_q;
  logic              l0_start_q;
  logic              l1_start_q;
  logic              spr_start_q;
  logic              render_abort_q;
  logic              overrun_q;
  logic              line_irq_q;
  logic              vsync_irq_q;

  // en bit order: [0]=L0, [1]=L1, [2]=SPR; lowest set bit wins.
  function automatic state_t pick(input logic [2:0] en);
    state_t s;
    s = IDLE;
    if (en[0])      s = L0;
    else if (en[1]) s = L1;
    else if (en[2]) s = SPR;
    return s;
  endfunction

  logic              line_go;
  logic              frame_end;
  logic              kick;
  logic              done_ok;
  logic [LINE_W-1:0] line_d;
  state_t            first_st;
  state_t            next_st;
  state_t            tgt_d;

  assign line_go   = start_of_line & frame_active_q
                   & (render_line_q < LAST_LINE);
  assign frame_end = start_of_line & frame_active_q
                   & (render_line_q == LAST_LINE);
  assign kick      = start_of_screen | line_go;
  assign line_d    = start_of_screen ? '0
                   : render_line_q + LINE_W'(1);
  assign first_st  = pick({spr_en, l1_en, l0_en});

  // A done coinciding with its own start pulse is stale and ignored.
  always_comb begin
    next_st = IDLE;
    done_ok = 1'b0;
    unique case (state_q)
      L0: begin
        done_ok = l0_done & ~l0_start_q;
        next_st = pick({en_q[2], en_q[1], 1'b0});
      end
      L1: begin
        done_ok = l1_done & ~l1_start_q;
        next_st = pick({en_q[2], 2'b00});
      end
      SPR: begin
        done_ok = spr_done & ~spr_start_q;
        next_st = IDLE;
      end
      default: begin
        done_ok = 1'b0;
        next_st = IDLE;
      end
    endcase
  end

  assign tgt_d = kick ? first_st : next_st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      en_q           <= '0;
      frame_active_q <= 1'b0;
      render_line_q  <= '0;
      linebuf_sel_q  <= 1'b0;
      l0_start_q     <= 1'b0;
      l1_start_q     <= 1'b0;
      spr_start_q    <= 1'b0;
      render_abort_q <= 1'b0;
      overrun_q      <= 1'b0;
      line_irq_q     <= 1'b0;
      vsync_irq_q    <= 1'b0;
    end else begin
      l0_start_q     <= 1'b0;
      l1_start_q     <= 1'b0;
      spr_start_q    <= 1'b0;
      render_abort_q <= 1'b0;
      line_irq_q     <= 1'b0;
      vsync_irq_q    <= end_of_screen;

      if (start_of_screen)
        frame_active_q <= 1'b1;
      else if (frame_end)
        frame_active_q <= 1'b0;

      if (overrun_clr)
        overrun_q <= 1'b0;

      if (kick) begin
        render_line_q <= line_d;
        linebuf_sel_q <= ~linebuf_sel_q;
        en_q          <= {spr_en, l1_en, l0_en};
        line_irq_q    <= (line_d == irq_line_cfg);
        // A new line while a stage is still pending kills it.
        if (state_q != IDLE) begin
          render_abort_q <= 1'b1;
          overrun_q      <= 1'b1;
        end
      end

      if (kick || done_ok) begin
        state_q     <= tgt_d;
        l0_start_q  <= (tgt_d == L0);
        l1_start_q  <= (tgt_d == L1);
        spr_start_q <= (tgt_d == SPR);
      end
    end
  end

  assign l0_start     = l0_start_q;
  assign l1_start     = l1_start_q;
  assign spr_start    = spr_start_q;
  assign render_line  = render_line_q;
  assign linebuf_sel  = linebuf_sel_q;
  assign render_abort = render_abort_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;
  assign line_irq     = line_irq_q;
  assign vsync_irq    = vsync_irq_q;

endmodule

// File: tb/tb_video_render_seq.sv
// Directed testbench for video_render_seq.
// Each scenario task drives stimulus and checks outputs inline.
module tb_video_render_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_of_screen;
  logic       start_of_line;
  logic       end_of_screen;
  logic       l0_en, l1_en, spr_en;
  logic       l0_done, l1_done, spr_done;
  logic [9:0] irq_line_cfg;
  logic       overrun_clr;
  logic       l0_start, l1_start, spr_start;
  logic [9:0] render_line;
  logic       linebuf_sel;
  logic       render_abort;
  logic       busy;
  logic       overrun;
  logic       line_irq;
  logic       vsync_irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  video_render_seq #(.NUM_LINES(480), .LINE_W(10)) dut (
    .clk(clk), .rst(rst),
    .start_of_screen(start_of_screen),
    .start_of_line(start_of_line),
    .end_of_screen(end_of_screen),
    .l0_en(l0_en), .l1_en(l1_en), .spr_en(spr_en),
    .l0_done(l0_done), .l1_done(l1_done), .spr_done(spr_done),
    .irq_line_cfg(irq_line_cfg),
    .overrun_clr(overrun_clr),
    .l0_start(l0_start), .l1_start(l1_start), .spr_start(spr_start),
    .render_line(render_line),
    .linebuf_sel(linebuf_sel),
    .render_abort(render_abort),
    .busy(busy),
    .overrun(overrun),
    .line_irq(line_irq),
    .vsync_irq(vsync_irq)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic kick_sos();
    start_of_screen = 1'b1;
    cyc();
    start_of_screen = 1'b0;
  endtask

  task automatic kick_sol();
    start_of_line = 1'b1;
    cyc();
    start_of_line = 1'b0;
  endtask

  // Let the start cycle pass, then pulse the done of stage s.
  task automatic finish(input int s);
    cyc();
    case (s)
      0: l0_done = 1'b1;
      1: l1_done = 1'b1;
      default: spr_done = 1'b1;
    endcase
    cyc();
    l0_done  = 1'b0;
    l1_done  = 1'b0;
    spr_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({l0_start, l1_start, spr_start, render_line, linebuf_sel,
         render_abort, busy, overrun, line_irq, vsync_irq} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0",
               {l0_start, l1_start, spr_start, render_line, linebuf_sel,
                render_abort, busy, overrun, line_irq, vsync_irq});
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_sequence();
    l0_en = 1; l1_en = 1; spr_en = 1;
    kick_sos();
    checks++;
    if ({render_line, linebuf_sel, l0_start, busy} !== {10'd0, 3'b111}) begin
      errors++;
      $display("FAIL seq_first got line=%0d sel=%b l0s=%b busy=%b exp 0 1 1 1",
               render_line, linebuf_sel, l0_start, busy);
    end
    finish(0);
    checks++;
    if ({l0_start, l1_start, spr_start} !== 3'b010) begin
      errors++;
      $display("FAIL seq_l1_start got %b exp 010",
               {l0_start, l1_start, spr_start});
    end
    // done in the same cycle as its start pulse must be ignored
    l1_done = 1'b1;
    cyc();
    l1_done = 1'b0;
    checks++;
    if ({spr_start, busy} !== 2'b01) begin
      errors++;
      $display("FAIL seq_early_done got spr_start=%b busy=%b exp 0 1",
               spr_start, busy);
    end
    l1_done = 1'b1;
    cyc();
    l1_done = 1'b0;
    checks++;
    if ({l1_start, spr_start} !== 2'b01) begin
      errors++;
      $display("FAIL seq_spr_start got %b exp 01", {l1_start, spr_start});
    end
    finish(2);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL seq_idle got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_skip();
    l0_en = 1; l1_en = 0; spr_en = 1;
    kick_sol();
    checks++;
    if ({render_line, linebuf_sel, l0_start} !== {10'd1, 2'b01}) begin
      errors++;
      $display("FAIL skip_kick got line=%0d sel=%b l0s=%b exp 1 0 1",
               render_line, linebuf_sel, l0_start);
    end
    finish(0);
    checks++;
    if ({l1_start, spr_start} !== 2'b01) begin
      errors++;
      $display("FAIL skip_l1 got l1s=%b sprs=%b exp 0 1", l1_start, spr_start);
    end
    finish(2);
    checks++;
    if ({l1_start, busy} !== 2'b00) begin
      errors++;
      $display("FAIL skip_done got l1s=%b busy=%b exp 0 0", l1_start, busy);
    end
    l0_en = 0; l1_en = 0; spr_en = 0;
    kick_sol();
    checks++;
    if ({render_line, linebuf_sel, l0_start, l1_start, spr_start, busy}
        !== {10'd2, 5'b10000}) begin
      errors++;
      $display("FAIL skip_none got line=%0d sel=%b starts=%b busy=%b exp 2 1 000 0",
               render_line, linebuf_sel, {l0_start, l1_start, spr_start}, busy);
    end
  endtask

  task automatic test_frame();
    int bad;
    int kicks;
    int irqs;
    bad = 0; kicks = 0; irqs = 0;
    l0_en = 1; l1_en = 1; spr_en = 1;
    irq_line_cfg = 10'd100;
    for (int i = 0; i < 480; i++) begin
      if (i == 0) kick_sos();
      else kick_sol();
      if (l0_start) kicks++;
      if (render_line !== 10'(i)) bad++;
      if (line_irq) begin
        irqs++;
        if (render_line !== 10'd100) bad++;
      end
      finish(0);
      finish(1);
      finish(2);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL frame_lines got %0d bad lines exp 0", bad);
    end
    checks++;
    if (kicks !== 480) begin
      errors++;
      $display("FAIL frame_kicks got %0d exp 480", kicks);
    end
    checks++;
    if (irqs !== 1) begin
      errors++;
      $display("FAIL frame_irq got %0d exp 1", irqs);
    end
    start_of_line = 1'b1;
    end_of_screen = 1'b1;
    cyc();
    start_of_line = 1'b0;
    end_of_screen = 1'b0;
    checks++;
    if ({l0_start, busy, render_line, vsync_irq} !== {2'b00, 10'd479, 1'b1}) begin
      errors++;
      $display("FAIL frame_end got l0s=%b busy=%b line=%0d vsync=%b exp 0 0 479 1",
               l0_start, busy, render_line, vsync_irq);
    end
    cyc();
    checks++;
    if (vsync_irq !== 1'b0) begin
      errors++;
      $display("FAIL vsync_width got %b exp 0", vsync_irq);
    end
    kick_sol();
    checks++;
    if ({l0_start, render_line} !== {1'b0, 10'd479}) begin
      errors++;
      $display("FAIL frame_stale_sol got l0s=%b line=%0d exp 0 479",
               l0_start, render_line);
    end
  endtask

  task automatic test_no_irq();
    int irqs;
    int bad;
    irqs = 0; bad = 0;
    l0_en = 0; l1_en = 0; spr_en = 0;
    irq_line_cfg = 10'd500;
    for (int i = 0; i < 480; i++) begin
      if (i == 0) kick_sos();
      else kick_sol();
      if (line_irq) irqs++;
      if (render_line !== 10'(i) || busy !== 1'b0) bad++;
      cyc();
    end
    checks++;
    if (irqs !== 0) begin
      errors++;
      $display("FAIL noirq_count got %0d exp 0", irqs);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL noirq_lines got %0d bad lines exp 0", bad);
    end
    kick_sol();
  endtask

  task automatic test_overrun();
    l0_en = 1; l1_en = 1; spr_en = 1;
    kick_sos();
    finish(0);
    kick_sol();
    checks++;
    if ({render_abort, overrun, l0_start, render_line} !== {3'b111, 10'd1}) begin
      errors++;
      $display("FAIL ovr_abort got abort=%b ovr=%b l0s=%b line=%0d exp 1 1 1 1",
               render_abort, overrun, l0_start, render_line);
    end
    cyc();
    checks++;
    if ({render_abort, overrun} !== 2'b01) begin
      errors++;
      $display("FAIL ovr_sticky got abort=%b ovr=%b exp 0 1",
               render_abort, overrun);
    end
    overrun_clr = 1'b1;
    cyc();
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear got %b exp 0", overrun);
    end
    overrun_clr = 1'b1;
    start_of_line = 1'b1;
    cyc();
    overrun_clr = 1'b0;
    start_of_line = 1'b0;
    checks++;
    if ({overrun, render_abort, render_line} !== {2'b11, 10'd2}) begin
      errors++;
      $display("FAIL ovr_set_wins got ovr=%b abort=%b line=%0d exp 1 1 2",
               overrun, render_abort, render_line);
    end
    finish(0);
    finish(1);
    finish(2);
    checks++;
    if ({busy, overrun} !== 2'b01) begin
      errors++;
      $display("FAIL ovr_drain got busy=%b ovr=%b exp 0 1", busy, overrun);
    end
  endtask

  task automatic test_reset_mid();
    l0_en = 1; l1_en = 1; spr_en = 1;
    kick_sol();
    finish(0);
    checks++;
    if ({l1_start, busy} !== 2'b11) begin
      errors++;
      $display("FAIL rmid_in_l1 got l1s=%b busy=%b exp 1 1", l1_start, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({l0_start, l1_start, spr_start, render_line, linebuf_sel,
         render_abort, busy, overrun, line_irq, vsync_irq} !== 19'd0) begin
      errors++;
      $display("FAIL rmid_outputs got %b exp 0",
               {l0_start, l1_start, spr_start, render_line, linebuf_sel,
                render_abort, busy, overrun, line_irq, vsync_irq});
    end
    cyc();
    rst = 1'b0;
    l1_done = 1'b1;
    cyc();
    l1_done = 1'b0;
    checks++;
    if ({l0_start, l1_start, spr_start, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL rmid_stray_done got starts=%b busy=%b exp 000 0",
               {l0_start, l1_start, spr_start}, busy);
    end
    kick_sol();
    checks++;
    if ({l0_start, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rmid_no_frame got l0s=%b busy=%b exp 0 0", l0_start, busy);
    end
    kick_sos();
    checks++;
    if ({render_line, linebuf_sel, l0_start} !== {10'd0, 2'b11}) begin
      errors++;
      $display("FAIL rmid_restart got line=%0d sel=%b l0s=%b exp 0 1 1",
               render_line, linebuf_sel, l0_start);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_of_screen = 0; start_of_line = 0; end_of_screen = 0;
    l0_en = 0; l1_en = 0; spr_en = 0;
    l0_done = 0; l1_done = 0; spr_done = 0;
    irq_line_cfg = 10'd500;
    overrun_clr = 0;
    test_reset();
    test_sequence();
    test_skip();
    test_frame();
    test_no_irq();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_render_seq.md
Name: video_render_seq

Overview:
- Per-line render scheduler driven by the VGA timing generator's start_of_screen / start_of_line / end_of_screen strobes.
- Runs the layer 0, layer 1 and sprite line renderers strictly one at a time, so they never contend for VRAM.
- Selects which half of the double-buffered line buffer is written, tracks the line being rendered, and raises line-compare and vsync interrupt pulses.
- Aborts a render that runs past its line slot and flags the overrun.

Parameters:
- NUM_LINES, 480, active display lines to render per frame.
- LINE_W, 10, width of line counters.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, asynchronous, active-high.
- start_of_screen  in  1  one-cycle strobe, last pixel of the line before display line 0.
- start_of_line  in  1  one-cycle strobe, last pixel of every line.
- end_of_screen  in  1  one-cycle strobe, last pixel of the last active line.
- l0_en, l1_en, spr_en  in  1 each  stage enables, sampled at each kick.
- l0_done, l1_done, spr_done  in  1 each  renderer completion pulses.
- irq_line_cfg  in  LINE_W  line-compare value.
- overrun_clr  in  1  clears the overrun flag.
- l0_start, l1_start, spr_start  out  1 each  one-cycle start pulses.
- render_line  out  LINE_W  line number the renderers must produce.
- linebuf_sel  out  1  line-buffer half being written; the display side reads the other half.
- render_abort  out  1  one-cycle pulse that terminates the active renderer.
- busy  out  1  high while any stage is pending.
- overrun  out  1  sticky; set when a render is aborted.
- line_irq  out  1  one-cycle pulse on line compare.
- vsync_irq  out  1  one-cycle pulse at end of screen.

Behaviour:
- Reset values: all outputs 0; render_line=0; state IDLE; frame_active=0. Reset asserted mid-render returns to IDLE immediately, and no done pulse is awaited afterwards.
- States: IDLE, L0, L1, SPR.
  - Next stage is chosen combinationally as the first enabled stage in the order L0 → L1 → SPR.
  - Disabled stages take zero cycles.
  - If no stage is enabled, the FSM stays or returns to IDLE.
- Kick. A kick occurs on a cycle N where either condition holds:
  - start_of_screen=1; or
  - start_of_line=1, frame_active=1 and render_line < NUM_LINES-1.
- Response to a kick, at cycle N+1:
  - render_line <= 0 for a start_of_screen kick, else render_line+1.
  - linebuf_sel toggles.
  - FSM enters the first enabled stage, and that stage's start pulse is high for exactly cycle N+1.
  - Enables are sampled at cycle N.
- Kick priority: start_of_screen and start_of_line are both high on the same cycle; start_of_screen wins (render_line → 0) and frame_active <= 1.
- Frame end:
  - start_of_line with render_line == NUM_LINES-1 clears frame_active and is not a kick.
  - No further starts occur until the next start_of_screen.
- Stage advance:
  - In stage X, the matching done input advances the FSM on the next cycle to the next enabled stage (asserting that stage's start) or to IDLE.
  - done inputs of non-current stages are ignored.
  - done in the same cycle as the stage's start pulse is ignored.
- busy = (state != IDLE).
- Overrun: a kick arriving while state != IDLE causes, at N+1:
  - render_abort=1 for one cycle;
  - overrun <= 1;
  - the new line then starts normally as above.
- overrun_clr clears overrun. If clr and a new overrun happen on the same cycle, set wins.
- line_irq: pulses at N+1 of a kick when the new render_line == irq_line_cfg.
- vsync_irq: registered copy of end_of_screen (1-cycle delay).

Test Plan:
- Reset, then start_of_screen with all enables=1 → cycle+1: render_line=0, linebuf_sel=1, l0_start=1. l0_done → l1_start next cycle. l1_done → spr_start. spr_done → busy=0.
- l1_en=0, spr_en=1, kick → l0_start; l0_done → spr_start on the next cycle, with no l1_start ever asserted. All enables 0 → no start pulses, busy stays 0, linebuf_sel still toggles.
- Full frame with immediate dones → exactly 480 kicks, render_line runs 0..479. The start_of_line after line 479 produces no start. vsync_irq asserts one cycle after end_of_screen.
- Withhold l1_done across a start_of_line → render_abort=1 and overrun=1 at N+1, and l0_start for the next line. overrun_clr=1 → overrun=0. Simultaneous clr and a new overrun → overrun=1.
- irq_line_cfg=100 → line_irq pulses exactly once per frame, together with render_line becoming 100. irq_line_cfg=500 → never pulses.
- Assert rst while in state L1 → all outputs 0 and state IDLE. A subsequent stray l1_done produces no start pulse. The next start_of_screen restarts at line 0.
